instruction_fetch: RTL and testbench

Fetch stage for the single-cycle RISC-V core: holds the program counter, drives the byte address `A` into `instruction_memory`, and returns the fetched word `RD` to decode as `Instr`. It selects the next PC between PC+4 and a branch/jump target, supports stall, and halts on `ebreak`. Optionally, it traps on misaligned control-flow targets.

---
 rtl/instruction_fetch.sv | 114 +++++++++++
 tb/tb_instruction_fetch.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Fetch stage: program counter, next-PC select (PC+4 / branch target), stall, ebreak halt.
// Optional FETCH_MISALIGN_TRAP_EN macro: misaligned control-flow targets enter a terminal TRAP state.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PCSrc,
    input  logic [31:0] PCTarget,
    input  logic        Stall,
    input  logic [31:0] RD,
    output logic [31:0] A,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic [31:0] Instr,
    output logic        InstrValid,
    output logic        Halted,
    output logic        Trap,
    output logic [31:0] TrapAddr,
    output logic [31:0] FetchCount
);

    localparam logic [31:0] ADDR_MASK = 32'(MEM_WORDS * 4 - 1);
    localparam logic [31:0] EBREAK    = 32'h0010_0073;
    localparam logic [31:0] NOP       = 32'h0000_0013;

    typedef enum logic [1:0] {BOOT, RUN, HALT, TRAP} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc_q, pc_nxt;
    logic [31:0] count_q, count_nxt;
    logic [31:0] pc_plus4;
    logic [31:0] target;
    logic        misaligned;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic [31:0] trap_addr_q;

    assign misaligned = (PCTarget[1:0] != 2'b00);
    assign target     = PCTarget & ADDR_MASK;
`else
    assign misaligned = 1'b0;
    assign target     = PCTarget & ~32'd3 & ADDR_MASK;
`endif

    assign pc_plus4 = (pc_q + 32'd4) & ADDR_MASK;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= BOOT;
            pc_q    <= RESET_PC;
            count_q <= '0;
        end else begin
            state   <= state_nxt;
            pc_q    <= pc_nxt;
            count_q <= count_nxt;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    // Target is captured only on the RUN->TRAP transition, so it stays frozen afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            trap_addr_q <= '0;
        end else if (state == RUN && state_nxt == TRAP) begin
            trap_addr_q <= PCTarget;
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_q;
        count_nxt = count_q;
        case (state)
            BOOT: state_nxt = RUN;
            RUN: begin
                if (!Stall) begin
                    if (RD == EBREAK) begin
                        state_nxt = HALT;
                    end else if (PCSrc && misaligned) begin
                        state_nxt = TRAP;
                    end else if (PCSrc) begin
                        pc_nxt    = target;
                        count_nxt = count_q + 32'd1;
                    end else begin
                        pc_nxt    = pc_plus4;
                        count_nxt = count_q + 32'd1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Status outputs are forced inactive while reset is held.
    assign A          = pc_q;
    assign PC         = pc_q;
    assign PCPlus4    = pc_plus4;
    assign FetchCount = count_q;
    assign InstrValid = (state == RUN) && !reset;
    assign Instr      = InstrValid ? RD : NOP;
    assign Halted     = (state == HALT) && !reset;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign Trap     = (state == TRAP) && !reset;
    assign TrapAddr = trap_addr_q;
`else
    assign Trap     = 1'b0;
    assign TrapAddr = '0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed scoreboard bench for instruction_fetch (RESET_PC=0, MEM_WORDS=256).
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        PCSrc = 1'b0;
    logic [31:0] PCTarget = '0;
    logic        Stall = 1'b0;
    logic [31:0] RD = 32'h1234_5678;
    logic [31:0] A, PC, PCPlus4, Instr, TrapAddr, FetchCount;
    logic        InstrValid, Halted, Trap;

    int checks = 0;
    int failures = 0;

    localparam logic [31:0] NOPW   = 32'h0000_0013;
    localparam logic [31:0] EBRK   = 32'h0010_0073;
    localparam logic [31:0] WORD   = 32'h1234_5678;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic [31:0] cnt;
        logic        valid;
        logic        halt;
        logic        trap;
        logic [31:0] taddr;
        logic [31:0] instr;
    } exp_t;

    exp_t sb[$];

    instruction_fetch #(.RESET_PC(32'h0), .MEM_WORDS(256)) dut (
        .clk(clk), .reset(reset), .PCSrc(PCSrc), .PCTarget(PCTarget), .Stall(Stall),
        .RD(RD), .A(A), .PC(PC), .PCPlus4(PCPlus4), .Instr(Instr),
        .InstrValid(InstrValid), .Halted(Halted), .Trap(Trap), .TrapAddr(TrapAddr),
        .FetchCount(FetchCount)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic stall, input logic src,
                         input logic [31:0] tgt, input logic [31:0] rd);
        reset = rst; Stall = stall; PCSrc = src; PCTarget = tgt; RD = rd;
    endtask

    task automatic expect_state(input string tag, input logic [31:0] pc, input logic [31:0] cnt,
                                input logic valid, input logic halt, input logic trap,
                                input logic [31:0] taddr);
        exp_t e;
        e.tag = tag; e.pc = pc; e.cnt = cnt; e.valid = valid; e.halt = halt;
        e.trap = trap; e.taddr = taddr; e.instr = valid ? RD : NOPW;
        sb.push_back(e);
    endtask

    task automatic check_sb();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            cmp({e.tag, ".A"}, A, e.pc);
            cmp({e.tag, ".PC"}, PC, e.pc);
            cmp({e.tag, ".PCPlus4"}, PCPlus4, (e.pc + 32'd4) & 32'h0000_03FF);
            cmp({e.tag, ".FetchCount"}, FetchCount, e.cnt);
            cmp({e.tag, ".InstrValid"}, {31'd0, InstrValid}, {31'd0, e.valid});
            cmp({e.tag, ".Instr"}, Instr, e.instr);
            cmp({e.tag, ".Halted"}, {31'd0, Halted}, {31'd0, e.halt});
            cmp({e.tag, ".Trap"}, {31'd0, Trap}, {31'd0, e.trap});
            cmp({e.tag, ".TrapAddr"}, TrapAddr, e.taddr);
        end
    endtask

    // Drive, queue the expected post-edge state, clock once and compare.
    task automatic step(input string tag, input logic rst, input logic stall, input logic src,
                        input logic [31:0] tgt, input logic [31:0] rd,
                        input logic [31:0] pc, input logic [31:0] cnt, input logic valid,
                        input logic halt, input logic trap, input logic [31:0] taddr);
        drive(rst, stall, src, tgt, rd);
        expect_state(tag, pc, cnt, valid, halt, trap, taddr);
        @(posedge clk);
        #1;
        check_sb();
    endtask

    initial begin
        // Reset held: outputs inactive, PC at RESET_PC.
        step("rst0", 1, 0, 0, 0, WORD, 32'h0, 0, 0, 0, 0, 0);
        step("rst1", 1, 0, 0, 0, WORD, 32'h0, 0, 0, 0, 0, 0);
        // BOOT cycle after release.
        drive(0, 0, 0, 0, WORD);
        #1;
        expect_state("boot", 32'h0, 0, 0, 0, 0, 0);
        check_sb();
        step("run0", 0, 0, 0, 0, WORD, 32'h0, 0, 1, 0, 0, 0);
        step("run4", 0, 0, 0, 0, WORD, 32'h4, 1, 1, 0, 0, 0);
        step("run8", 0, 0, 0, 0, WORD, 32'h8, 2, 1, 0, 0, 0);
        step("run12", 0, 0, 0, 0, WORD, 32'hC, 3, 1, 0, 0, 0);

        // Stall holds PC and count even with PCSrc asserted.
        step("br8", 0, 0, 1, 32'h8, WORD, 32'h8, 4, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            step("stall", 0, 1, 1, 32'h40, WORD, 32'h8, 4, 1, 0, 0, 0);
        step("unstall", 0, 0, 1, 32'h40, WORD, 32'h40, 5, 1, 0, 0, 0);

        // Wrap-around of sequential and branch addresses.
        step("br3fc", 0, 0, 1, 32'h3FC, WORD, 32'h3FC, 6, 1, 0, 0, 0);
        step("wrapseq", 0, 0, 0, 0, WORD, 32'h0, 7, 1, 0, 0, 0);
        step("wrapbr", 0, 0, 1, 32'h404, WORD, 32'h4, 8, 1, 0, 0, 0);

        // Misaligned target.
        step("br40", 0, 0, 1, 32'h40, WORD, 32'h40, 9, 1, 0, 0, 0);
`ifdef FETCH_MISALIGN_TRAP_EN
        step("mis", 0, 0, 1, 32'h42, WORD, 32'h40, 9, 0, 0, 1, 32'h42);
        step("trapfrz0", 0, 0, 1, 32'h100, WORD, 32'h40, 9, 0, 0, 1, 32'h42);
        step("trapfrz1", 0, 0, 0, 0, WORD, 32'h40, 9, 0, 0, 1, 32'h42);
`else
        step("mis", 0, 0, 1, 32'h42, WORD, 32'h40, 10, 1, 0, 0, 0);
`endif
        step("rst2", 1, 0, 0, 0, WORD, 32'h0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, WORD);
        #1;
        expect_state("boot2", 32'h0, 0, 0, 0, 0, 0);
        check_sb();
        step("run0b", 0, 0, 0, 0, WORD, 32'h0, 0, 1, 0, 0, 0);

        // ebreak halts at its own address and freezes.
        step("br20", 0, 0, 1, 32'h20, WORD, 32'h20, 1, 1, 0, 0, 0);
        step("ebreak", 0, 0, 0, 0, EBRK, 32'h20, 1, 0, 1, 0, 0);
        for (int i = 0; i < 10; i++)
            step("halted", 0, 0, 1, 32'h100, WORD, 32'h20, 1, 0, 1, 0, 0);
        step("rst3", 1, 0, 0, 0, WORD, 32'h0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, WORD);
        #1;
        expect_state("boot3", 32'h0, 0, 0, 0, 0, 0);
        check_sb();
        step("run0c", 0, 0, 0, 0, WORD, 32'h0, 0, 1, 0, 0, 0);

        // Reset during a stall at 0x80.
        step("br80", 0, 0, 1, 32'h80, WORD, 32'h80, 1, 1, 0, 0, 0);
        step("stall80", 0, 1, 0, 0, WORD, 32'h80, 1, 1, 0, 0, 0);
        step("rststall", 1, 1, 0, 0, WORD, 32'h0, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, WORD);
        #1;
        expect_state("boot4", 32'h0, 0, 0, 0, 0, 0);
        check_sb();
        step("bootstall", 0, 1, 1, 32'h80, WORD, 32'h0, 0, 1, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
